// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and port slice helper for the register file
package regfile_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_NUM_RD = 2;
  function automatic int port_lo(input int port, input int width);
    return port * width;
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bitmap with lock-over-write priority
module regfile_scoreboard #(
  parameter int DEPTH = 16,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              lock_en,
  input  logic [ADDR_W-1:0] lock_addr,
  output logic [DEPTH-1:0]  busy_vec
);
  logic [DEPTH-1:0] busy_nxt;
  // a new producer issuing on the same edge as the old one retiring keeps the register busy
  always_comb begin
    busy_nxt = busy_vec;
    for (int k = 0; k < DEPTH; k++)
      if (ZERO_REG == 0 || k != 0)
        busy_nxt[k] = (lock_en && lock_addr == ADDR_W'(k)) ? 1'b1 :
                      (wr_en && wr_addr == ADDR_W'(k)) ? 1'b0 : busy_vec[k];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) busy_vec <= '0;
    else busy_vec <= busy_nxt;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with write bypass and RAW scoreboard
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int NUM_RD = DEF_NUM_RD,
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     lock_en,
  input  logic [ADDR_W-1:0]        lock_addr,
  output logic [DEPTH-1:0]         busy_vec
);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  logic [DATA_W-1:0] mem [0:DEPTH-1];
  regfile_scoreboard #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_sb (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .lock_en(lock_en), .lock_addr(lock_addr), .busy_vec(busy_vec)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++)
        if (wr_en && wr_addr == ADDR_W'(k) && (ZERO_REG == 0 || k != 0)) mem[k] <= wr_data;
    end
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic valid, wr_hit, lock_hit, b_nxt, b_q;
    logic [DATA_W-1:0] d_nxt, d_q;
    assign a = rd_addr[port_lo(i, ADDR_W) +: ADDR_W];
    // invalid addresses (out of range or hardwired zero) never hit the write or lock terms
    always_comb begin
      valid = ({1'b0, a} < DEPTH_L) && !(ZERO_REG != 0 && a == '0);
      wr_hit = wr_en && wr_addr == a;
      lock_hit = lock_en && lock_addr == a;
      d_nxt = !valid ? '0 : (BYPASS != 0 && wr_hit) ? wr_data : mem[a];
      b_nxt = valid && ((busy_vec[a] && !wr_hit) || lock_hit);
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        d_q <= '0;
        b_q <= 1'b0;
      end else if (rd_en[i]) begin
        d_q <= d_nxt;
        b_q <= b_nxt;
      end
    assign rd_data[port_lo(i, DATA_W) +: DATA_W] = d_q;
    assign rd_busy[i] = b_q;
  end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file with a per-register scoreboard, used as the next-generation architectural register file of the RISC datapath. It provides a configurable number of synchronous read ports and one synchronous write port. Optional write-to-read bypass and a hardwired zero register are selectable by parameter. A busy bitmap tracks registers with an outstanding producer, so issue logic can detect RAW hazards.

## Interface
- DATA_W, 16: register width in bits
- DEPTH, 16: number of registers, 2..256
- ADDR_W, $clog2(DEPTH): address width
- NUM_RD, 2: number of read ports, 1..4
- ZERO_REG, 1: 1 = register 0 reads 0, ignores writes and locks, never busy
- BYPASS, 1: 1 = same-edge write is forwarded to a same-edge read of the same address

- clk  in  1  sole clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- rd_en  in  NUM_RD  per-port read enable
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  registered read data, packed the same way
- rd_busy  out  NUM_RD  registered busy flag of the register read on each port
- wr_en  in  1  write enable
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- lock_en  in  1  mark lock_addr busy (producer issued)
- lock_addr  in  ADDR_W  register to lock
- busy_vec  out  DEPTH  current busy bitmap, bit k = register k

## Operation
- Storage: DEPTH x DATA_W flops. Reset clears every register to 0, with no file preload. Reset also clears the busy bitmap and all rd_data/rd_busy outputs to 0.
- Write: at a posedge with wr_en=1, the register at wr_addr takes wr_data and its busy bit clears.
- Ignored writes: a write is dropped when wr_addr >= DEPTH, or when ZERO_REG=1 and wr_addr=0.
- Read, port i: at a posedge with rd_en[i]=1, rd_data[i] captures the register at rd_addr[i].
  - With BYPASS=1 and a same-edge write to the same address, wr_data is captured instead. With BYPASS=0, the pre-write value is captured.
  - When rd_en[i]=0, rd_data[i] and rd_busy[i] hold their previous values.
  - An address >= DEPTH, or address 0 with ZERO_REG=1, returns 0 with busy 0.
- rd_busy[i] is captured as (busy[a] AND NOT same-edge write to a) OR (same-edge lock of a). A read that coincides with a lock of its own address therefore returns the old data flagged busy.
- Scoreboard: at a posedge with lock_en=1, busy[lock_addr] is set.
  - If lock and write target the same address on the same edge, the lock wins: data is written and the busy bit stays 1, because a new producer has issued.
  - Locks to out-of-range addresses, or to register 0 with ZERO_REG=1, are ignored.
  - Locking an already-busy register is legal and leaves it busy.
- Multiple read ports may read the same address with no restriction. The ports are fully independent.

## Timing
- Read latency is 1 cycle: an address presented before edge N gives rd_data/rd_busy valid after edge N, stable for the whole of cycle N+1.
- Write latency is 1 edge. With BYPASS=0, a read of the written register reflects the new value at the edge after the write edge.
- busy_vec is a direct register output: it changes only on posedge or reset, with no combinational path from inputs.
- Reset asserted mid-operation clears all state asynchronously. Writes, locks and reads presented while rst_n=0 are discarded. The first edge after deassertion operates normally.
- There are no combinational input-to-output paths.

## Structure
- Shared package regfile_pkg holds the default parameter constants (DATA_W, DEPTH, NUM_RD) and a function that returns the per-port address/data slice indices, also used by the decode stage.
- Sub-module regfile_scoreboard (DEPTH, ADDR_W, ZERO_REG) owns the busy bitmap, lock/clear priority and busy_vec. The top module instantiates it once and derives rd_busy from its bitmap plus the same-edge lock/write terms.
- Read ports are produced with a generate loop over NUM_RD.

## Test plan
- Reset: write 16'hBEEF to r5, then pulse rst_n low mid-cycle -> rd_data, rd_busy and busy_vec are immediately 0, and a later read of r5 returns 16'h0000.
- Basic write/read: write r3=16'h1234, then on the next edge read r3 on port 0 and r3 on port 1 -> both ports show 16'h1234 one cycle later.
- Bypass, run once with BYPASS=1 and once with BYPASS=0: r7 holds 16'h00AA; on the same edge write r7=16'h5555 and read r7 -> port shows 16'h5555 (BYPASS=1) or 16'h00AA (BYPASS=0), and reads 16'h5555 on the following read in both cases.
- Zero register, ZERO_REG=1: write r0=16'hFFFF and lock r0 -> read r0 gives 0, busy 0, busy_vec[0]=0.
- Scoreboard: lock r4 -> busy_vec[4]=1 and a read of r4 reports rd_busy=1. Lock and write r4=16'h0042 on the same edge -> busy stays 1 and data is 16'h0042. A later write with no lock -> busy 0.
- Hold and out-of-range, DEPTH=12: deassert rd_en with the address changing -> outputs hold their values. Read r13 -> 0 and busy 0. Write r13 -> no register changes.
